mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage directly downstream of the EX/MEM register. Runs loads and stores
//  against a variable-latency data memory over a req/ack handshake and stalls upstream
//  while an access is outstanding. Owns the MEM/WB pipeline register that feeds write-back.
//  Checks word alignment and enforces a bus timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max BUSY cycles waiting for mem_ack_i before abort (1..2^CNT_W-1)
//  CNT_W           8    width of the timeout counter
// PORTS
//  clk_i         in   1   clock, rising edge
//  rst_n_i       in   1   reset, asynchronous, active-low
//  MemRd_i       in   1   load request (from EX/MEM)
//  MemWr_i       in   1   store request (from EX/MEM)
//  MemtoReg_i    in   1   WB selects memory data (from EX/MEM)
//  RegWrite_i    in   1   WB register write enable (from EX/MEM)
//  ALUResult_i   in   32  byte address / ALU result (from EX/MEM)
//  MemData_i     in   32  store data (from EX/MEM)
//  WriteReg_i    in   5   destination register (from EX/MEM)
//  stall_o       out  1   comb; 1 = upstream (PC, IF/ID, ID/EX, EX/MEM) holds
//  mem_req_o     out  1   registered memory request
//  mem_we_o      out  1   1 = write
//  mem_addr_o    out  32  word-aligned address
//  mem_wdata_o   out  32  write data
//  mem_ack_i     in   1   memory completion, single-cycle pulse
//  mem_rdata_i   in   32  read data, valid when mem_ack_i=1
//  RegWrite_o    out  1   MEM/WB register write enable
//  MemtoReg_o    out  1   MEM/WB write-back select
//  ReadData_o    out  32  MEM/WB load data
//  ALUResult_o   out  32  MEM/WB ALU result
//  WriteReg_o    out  5   MEM/WB destination register
//  misalign_o    out  1   1-cycle pulse, aligned with MEM/WB output of a misaligned access
//  timeout_o     out  1   1-cycle pulse, aligned with MEM/WB output of an aborted access
// BEHAVIOUR
//  - Reset (rst_n_i=0, async): state=IDLE, counter=0, every registered output=0;
//    mem_req_o drops immediately, including mid-access. stall_o=0.
//  - acc = MemRd_i|MemWr_i.
//  - aligned = (ALUResult_i[1:0]==0).
//  - MemRd_i and MemWr_i both set: treated as a store; ReadData_o=0.
//  - FSM states:
//    IDLE: acc&aligned -> latch req/we/addr/wdata, go BUSY.
//    BUSY: mem_ack_i -> capture rdata, go DONE.
//      Counter reaches TIMEOUT_CYCLES -> drop req, flag timeout, go DONE.
//    DONE: go IDLE. The new EX/MEM contents are sampled next cycle.
//  - stall_o = (IDLE & acc & aligned) | BUSY. stall_o=0 in DONE.
//  - mem_req_o=1 throughout BUSY only. mem_addr_o, mem_we_o and mem_wdata_o are stable
//    while req=1. Falls the cycle after ack.
//  - mem_ack_i outside BUSY is ignored.
//  - MEM/WB loads every edge:
//    - stall_o=1: loads a bubble (RegWrite_o=0, MemtoReg_o=0, flags 0).
//    - stall_o=0: loads the EX/MEM fields. ReadData_o = captured rdata for loads, 0 otherwise.
//  - Latency:
//    - Non-memory instruction: 1 cycle, no stall.
//    - Memory access with ack k cycles after req rises (k>=0, ack in same cycle = 0):
//      2+k stall cycles, then MEM/WB loads at the end of DONE.
//  - Misaligned acc: no request, no stall. MEM/WB loads with RegWrite_o=0 and misalign_o=1.
//  - Timeout: MEM/WB loads with RegWrite_o=0, ReadData_o=0, timeout_o=1. Counter cleared
//    on leaving BUSY.
// TESTING
//  1. ALU op, RegWrite_i=1, WriteReg_i=5, ALUResult_i=0x1234
//     -> next edge WriteReg_o=5, ALUResult_o=0x1234, RegWrite_o=1, stall_o never 1.
//  2. Load addr 0x40, ack 3 cycles after req, rdata=0xDEADBEEF
//     -> stall_o high 5 cycles, exactly one req, mem_we_o=0, then ReadData_o=0xDEADBEEF
//        with RegWrite_o=1. Bubbles during stall.
//  3. Store addr 0x80 data 0xCAFEF00D, ack 0 cycles after req
//     -> mem_we_o=1, addr 0x80, wdata 0xCAFEF00D; 2 stall cycles.
//  4. Load addr 0x42 -> no req, no stall, misalign_o=1, RegWrite_o=0.
//  5. Load with no ack, TIMEOUT_CYCLES=4 -> req drops after 4 BUSY cycles, timeout_o=1,
//     RegWrite_o=0. Stray ack afterwards is ignored.
//  6. Assert rst_n_i=0 while in BUSY -> mem_req_o, stall_o and all outputs 0 immediately.
//     After release, a new load completes normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores over a req/ack memory bus with alignment
// checking and a bus timeout, and owns the MEM/WB pipeline register.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        MemRd_i,
    input  logic        MemWr_i,
    input  logic        MemtoReg_i,
    input  logic        RegWrite_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] MemData_i,
    input  logic [4:0]  WriteReg_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] ReadData_o,
    output logic [31:0] ALUResult_o,
    output logic [4:0]  WriteReg_o,
    output logic        misalign_o,
    output logic        timeout_o,
    output logic [1:0]  dbg_state_o
);

    // Bus handshake: mem_req_o is held high with stable we/addr/wdata until a
    // single-cycle mem_ack_i arrives (or the timeout fires); ack is ignored otherwise.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              abort_q, abort_d;

    logic              rw_q, rw_d;
    logic              mtr_q, mtr_d;
    logic [31:0]       rd_q, rd_d;
    logic [31:0]       alu_q, alu_d;
    logic [4:0]        wreg_q, wreg_d;
    logic              mis_q, mis_d;
    logic              tmo_q, tmo_d;

    logic              acc, aligned, is_load, stall;

    assign acc     = MemRd_i | MemWr_i;
    assign aligned = (ALUResult_i[1:0] == 2'b00);
    assign is_load = MemRd_i & ~MemWr_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        abort_d = abort_q;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (acc && aligned) begin
                    stall   = 1'b1;
                    req_d   = 1'b1;
                    we_d    = MemWr_i;
                    addr_d  = {ALUResult_i[31:2], 2'b00};
                    wdata_d = MemData_i;
                    rdata_d = 32'd0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (mem_ack_i) begin
                    rdata_d = mem_rdata_i;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else if (cnt_q == TO_LAST) begin
                    req_d   = 1'b0;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // MEM/WB next value: a bubble while stalled, otherwise the held EX/MEM fields.
    always_comb begin
        rw_d   = 1'b0;
        mtr_d  = 1'b0;
        rd_d   = 32'd0;
        alu_d  = 32'd0;
        wreg_d = 5'd0;
        mis_d  = 1'b0;
        tmo_d  = 1'b0;
        if (!stall) begin
            mtr_d  = MemtoReg_i;
            alu_d  = ALUResult_i;
            wreg_d = WriteReg_i;
            mis_d  = (state_q == S_IDLE) && acc && !aligned;
            tmo_d  = (state_q == S_DONE) && abort_q;
            rw_d   = RegWrite_i && !mis_d && !tmo_d;
            if ((state_q == S_DONE) && is_load && !abort_q)
                rd_d = rdata_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            abort_q <= 1'b0;
            rw_q    <= 1'b0;
            mtr_q   <= 1'b0;
            rd_q    <= 32'd0;
            alu_q   <= 32'd0;
            wreg_q  <= 5'd0;
            mis_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            abort_q <= abort_d;
            rw_q    <= rw_d;
            mtr_q   <= mtr_d;
            rd_q    <= rd_d;
            alu_q   <= alu_d;
            wreg_q  <= wreg_d;
            mis_q   <= mis_d;
            tmo_q   <= tmo_d;
        end
    end

    // Reset forces stall low even though IDLE with a pending access would raise it.
    assign stall_o     = stall & rst_n_i;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign RegWrite_o  = rw_q;
    assign MemtoReg_o  = mtr_q;
    assign ReadData_o  = rd_q;
    assign ALUResult_o = alu_q;
    assign WriteReg_o  = wreg_q;
    assign misalign_o  = mis_q;
    assign timeout_o   = tmo_q;
    assign dbg_state_o = state_q;

endmodule
